emif_dma_ctrl: RTL

Single-channel DMA sequencer driven by the EMIF register file's `dma*_*` control words, instantiated once per channel (dma0, dma1). It latches start address, package size and total size on a start edge and splits the transfer into packages. It issues one package request at a time to the downstream RAM/transfer engine over a req/ack handshake and waits for per-package completion. Progress and status are returned in 16-bit low/high words that the register file maps back onto the DSP-visible addresses.

---
 rtl/emif_dma_pkg.sv | 25 ++
 rtl/emif_dma_watchdog.sv | 27 ++
 rtl/emif_dma_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/emif_dma_pkg.sv
// Shared types and constants for the EMIF DMA channel sequencer.
package emif_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_WAIT_DONE,
        ST_FINISH
    } dma_state_e;

    localparam int STS_BUSY        = 0;
    localparam int STS_DONE        = 1;
    localparam int STS_ERR_SIZE    = 2;
    localparam int STS_ERR_TIMEOUT = 3;
    localparam int STS_ABORT       = 4;

    localparam int START_BIT = 0;
    localparam int ABORT_BIT = 1;

    function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/emif_dma_watchdog.sv
// Cycle counter for the package-completion wait; TIMEOUT_CYC of 0 disables it.
module emif_dma_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + CW'(1);
    end

    // Fires during the TIMEOUT_CYC-th enabled cycle, so the owner leaves on that edge.
    assign expired = (TIMEOUT_CYC != 0) && en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/emif_dma_ctrl.sv
// Single-channel DMA sequencer: splits a transfer into packages and hands them downstream.
module emif_dma_ctrl
    import emif_dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] cfg_start,
    input  logic [15:0] cfg_trans_size_low,
    input  logic [15:0] cfg_trans_size_high,
    input  logic [15:0] cfg_all_trans_size_low,
    input  logic [15:0] cfg_all_trans_size_high,
    input  logic [15:0] cfg_addr_low,
    input  logic [15:0] cfg_addr_high,
    output logic        pkt_req,
    output logic [31:0] pkt_addr,
    output logic [31:0] pkt_len,
    input  logic        pkt_ack,
    input  logic        pkt_done,
    output logic [15:0] sts_state,
    output logic [15:0] sts_pkg_num_low,
    output logic [15:0] sts_pkg_num_high,
    output logic [15:0] sts_remain_low,
    output logic [15:0] sts_remain_high,
    output logic        irq_done
);
    dma_state_e  state;
    logic        start_q;
    logic [31:0] trans;
    logic [31:0] remain;
    logic [31:0] pkg_num;
    logic [4:0]  status;
    logic        wd_expired;

    logic [31:0] cfg_trans, cfg_all, cfg_addr, next_remain;
    logic        start_edge, abort;
    logic        unused_cfg;

    assign cfg_trans   = {cfg_trans_size_high, cfg_trans_size_low};
    assign cfg_all     = {cfg_all_trans_size_high, cfg_all_trans_size_low};
    assign cfg_addr    = {cfg_addr_high, cfg_addr_low};
    assign start_edge  = cfg_start[START_BIT] & ~start_q;
    assign abort       = cfg_start[ABORT_BIT];
    assign next_remain = remain - pkt_len;
    assign unused_cfg  = ^cfg_start[15:2];

    emif_dma_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clr     (state != ST_WAIT_DONE),
        .en      (state == ST_WAIT_DONE),
        .expired (wd_expired)
    );

    // pkt_addr doubles as the running transfer address.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            start_q  <= 1'b0;
            trans    <= '0;
            remain   <= '0;
            pkg_num  <= '0;
            status   <= '0;
            pkt_req  <= 1'b0;
            pkt_addr <= '0;
            pkt_len  <= '0;
            irq_done <= 1'b0;
        end else begin
            start_q  <= cfg_start[START_BIT];
            irq_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        status[4:1] <= '0;
                        pkg_num     <= '0;
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        status[STS_ABORT] <= 1'b1;
                        status[STS_BUSY]  <= 1'b0;
                        state             <= ST_IDLE;
                    end else if (cfg_trans == '0 || cfg_all == '0) begin
                        status[STS_ERR_SIZE] <= 1'b1;
                        state                <= ST_IDLE;
                    end else begin
                        trans            <= cfg_trans;
                        remain           <= cfg_all;
                        pkt_addr         <= cfg_addr;
                        pkt_len          <= min32(cfg_all, cfg_trans);
                        pkt_req          <= 1'b1;
                        status[STS_BUSY] <= 1'b1;
                        state            <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (abort) begin
                        pkt_req           <= 1'b0;
                        status[STS_ABORT] <= 1'b1;
                        status[STS_BUSY]  <= 1'b0;
                        state             <= ST_IDLE;
                    end else if (pkt_ack) begin
                        pkt_req <= 1'b0;
                        state   <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (pkt_done) begin
                        pkt_addr <= pkt_addr + pkt_len;
                        remain   <= next_remain;
                        pkg_num  <= pkg_num + 32'd1;
                        pkt_len  <= min32(next_remain, trans);
                    end
                    // Abort still lets a coincident completion be counted.
                    if (abort) begin
                        status[STS_ABORT] <= 1'b1;
                        status[STS_BUSY]  <= 1'b0;
                        state             <= ST_IDLE;
                    end else if (pkt_done) begin
                        if (next_remain == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            pkt_req <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end else if (wd_expired) begin
                        status[STS_ERR_TIMEOUT] <= 1'b1;
                        status[STS_BUSY]        <= 1'b0;
                        state                   <= ST_IDLE;
                    end
                end
                ST_FINISH: begin
                    status[STS_BUSY] <= 1'b0;
                    status[STS_DONE] <= 1'b1;
                    irq_done         <= 1'b1;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sts_state        = {11'd0, status};
    assign sts_pkg_num_low  = pkg_num[15:0];
    assign sts_pkg_num_high = pkg_num[31:16];
    assign sts_remain_low   = remain[15:0];
    assign sts_remain_high  = remain[31:16];

endmodule
